load_store_unit: RTL

//  Memory-access stage downstream of the N-bit ALU. Takes the ALU result as the effective address,

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory port between the load/store unit and the memory.
// It uses a req/gnt handshake for the request and a separate rvalid strobe
// that returns load data.
//   mem_req    master->slave  request, held until mem_gnt
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  word-aligned byte address
//   mem_be     master->slave  byte enables
//   mem_wdata  master->slave  lane-replicated store data
//   mem_gnt    slave->master  request accepted this cycle
//   mem_rvalid slave->master  mem_rdata valid this cycle
//   mem_rdata  slave->master  read data
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage. The ALU result is the effective address. The unit runs
// one load or store per request over a req/gnt/rvalid memory port. It
// generates byte enables and replicates store data across the byte lanes.
// It aligns load data and sign- or zero-extends it for writeback.
// Ports:
//   clk_i, rst_n_i       clock (rising edge), async active-low reset
//   req_i                start an access; sampled only while idle
//   we_i, size_i         store/load; 00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i           loads: zero-extend instead of sign-extend
//   addr_i, wdata_i      effective address, right-justified store data
//   busy_o, done_o       transfer in flight / one-cycle completion pulse
//   rdata_o              last successful load result
//   misalign_o           alignment reject, valid with done_o
//   buserr_o             rvalid timeout, valid with done_o
//   mem                  data-memory port (master side)
// ----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              misalign_o,
   output logic              buserr_o,
   load_store_unit_if.master mem
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

   logic [1:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misalign_q, misalign_d;
   logic              buserr_q, buserr_d;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = off[0];
         2'b10:   is_misaligned = |off;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   byte_en = 4'b0001 << off;
         2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   store_data = {4{d[7:0]}};
         2'b01:   store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Half accesses only reach here aligned, so the upper/lower half select is exact.
   function automatic logic [31:0] load_data(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = off[1] ? d[31:16] : d[15:0];
      case (size)
         2'b00:   load_data = {{24{b[7] & ~uns}}, b};
         2'b01:   load_data = {{16{h[15] & ~uns}}, h};
         default: load_data = d;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      buserr_d   = buserr_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               uns_d   = unsigned_i;
               addr_d  = addr_i;
               be_d    = byte_en(size_i, addr_i[1:0]);
               wdata_d = store_data(size_i, wdata_i);
               if (is_misaligned(size_i, addr_i[1:0])) begin
                  misalign_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_d = '0;
            if (mem.mem_gnt) state_d = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // Data arriving on the last allowed cycle still wins over the timeout.
            if (mem.mem_rvalid) begin
               rdata_d = load_data(size_q, uns_q, addr_q[1:0], mem.mem_rdata);
               state_d = S_DONE;
            end else if (cnt_q + 16'd1 == TIMEOUT_C) begin
               buserr_d = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: begin
            cnt_d      = '0;
            misalign_d = 1'b0;
            buserr_d   = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         buserr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         buserr_q   <= buserr_d;
      end
   end

   // Request and write enable come straight from state, so reset drops them at once.
   assign mem.mem_req   = (state_q == S_REQ);
   assign mem.mem_we    = (state_q == S_REQ) & we_q;
   assign mem.mem_be    = (state_q == S_REQ) ? be_q : 4'b0000;
   assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem.mem_wdata = wdata_q;

   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_DONE);
   assign rdata_o    = rdata_q;
   assign misalign_o = misalign_q;
   assign buserr_o   = buserr_q;

endmodule
